// File: rtl/duty_ramp.sv
// Breathing-LED duty sequencer: ramps a PWM duty value up, dwells, ramps down, dwells,
// advancing only on the downstream PWM generator's period-boundary pulse (co).
`timescale 1ns/1ps

module duty_ramp #(
    parameter int unsigned M    = 256,
    parameter int unsigned STEP = 1,
    parameter int unsigned DIV  = 4,
    parameter int unsigned HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 co,
    output logic [$clog2(M)-1:0] duty,
    output logic                 rising,
    output logic                 cycle_done
);

    localparam int unsigned DW  = $clog2(M);
    localparam int unsigned WW  = DW + 1;
    localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [WW-1:0]  StepW    = WW'(STEP);
    localparam logic [WW-1:0]  MaxW     = WW'(M - 1);
    localparam logic [DW-1:0]  DutyMax  = DW'(M - 1);
    localparam logic [DCW-1:0] DivLast  = DCW'(DIV - 1);
    localparam logic [HCW-1:0] HoldLast = HCW'(HOLD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StUp,
        StHoldHi,
        StDown,
        StHoldLo
    } state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  duty_q, duty_d;
    logic [DCW-1:0] div_cnt_q, div_cnt_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           cycle_done_q, cycle_done_d;

    // One extra bit: duty+STEP cannot overflow and duty-STEP borrows into the MSB.
    logic [WW-1:0] duty_w;
    logic [WW-1:0] up_w;
    logic [WW-1:0] dn_w;
    logic          up_clamp;
    logic          dn_clamp;

    assign duty_w   = {1'b0, duty_q};
    assign up_w     = duty_w + StepW;
    assign dn_w     = duty_w - StepW;
    assign up_clamp = (up_w >= MaxW);
    assign dn_clamp = dn_w[WW-1] || (dn_w == '0);

    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        div_cnt_d    = div_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        cycle_done_d = 1'b0;

        if (!en) begin
            state_d    = StIdle;
            duty_d     = '0;
            div_cnt_d  = '0;
            hold_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d    = StUp;
                    duty_d     = '0;
                    div_cnt_d  = '0;
                    hold_cnt_d = '0;
                end
                StUp: begin
                    if (co) begin
                        if (div_cnt_q == DivLast) begin
                            div_cnt_d = '0;
                            if (up_clamp) begin
                                duty_d  = DutyMax;
                                state_d = StHoldHi;
                            end else begin
                                duty_d = up_w[DW-1:0];
                            end
                        end else begin
                            div_cnt_d = div_cnt_q + DCW'(1);
                        end
                    end
                end
                StHoldHi: begin
                    if (co) begin
                        if (hold_cnt_q == HoldLast) begin
                            hold_cnt_d = '0;
                            state_d    = StDown;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HCW'(1);
                        end
                    end
                end
                StDown: begin
                    if (co) begin
                        if (div_cnt_q == DivLast) begin
                            div_cnt_d = '0;
                            if (dn_clamp) begin
                                duty_d  = '0;
                                state_d = StHoldLo;
                            end else begin
                                duty_d = dn_w[DW-1:0];
                            end
                        end else begin
                            div_cnt_d = div_cnt_q + DCW'(1);
                        end
                    end
                end
                StHoldLo: begin
                    if (co) begin
                        if (hold_cnt_q == HoldLast) begin
                            hold_cnt_d   = '0;
                            state_d      = StUp;
                            cycle_done_d = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HCW'(1);
                        end
                    end
                end
                default: begin
                    state_d    = StIdle;
                    duty_d     = '0;
                    div_cnt_d  = '0;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            duty_q       <= '0;
            div_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            div_cnt_q    <= div_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign duty       = duty_q;
    assign rising     = (state_q == StUp) || (state_q == StHoldHi);
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: three parameter sets share one stimulus stream and are checked every
// cycle against an arithmetic model, plus literal expectations for the scripted breathing run.
`timescale 1ns/1ps

module tb_duty_ramp;

    localparam int M0 = 16, S0 = 4,  D0 = 2, H0 = 1;
    localparam int M1 = 16, S1 = 15, D1 = 2, H1 = 1;
    localparam int M2 = 20, S2 = 3,  D2 = 3, H2 = 3;

    localparam int PhIdle = 0, PhUp = 1, PhHi = 2, PhDown = 3, PhLo = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       co  = 1'b0;
    logic [3:0] duty0, duty1;
    logic [4:0] duty2;
    logic       rising0, rising1, rising2;
    logic       done0, done1, done2;

    duty_ramp #(.M(M0), .STEP(S0), .DIV(D0), .HOLD(H0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .co(co),
        .duty(duty0), .rising(rising0), .cycle_done(done0)
    );
    duty_ramp #(.M(M1), .STEP(S1), .DIV(D1), .HOLD(H1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .co(co),
        .duty(duty1), .rising(rising1), .cycle_done(done1)
    );
    duty_ramp #(.M(M2), .STEP(S2), .DIV(D2), .HOLD(H2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .co(co),
        .duty(duty2), .rising(rising2), .cycle_done(done2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 0;

    int pm[3] = '{M0, M1, M2};
    int ps[3] = '{S0, S1, S2};
    int pd[3] = '{D0, D1, D2};
    int ph[3] = '{H0, H1, H2};

    // Model: phase, duty, and co pulses seen in the current step or dwell.
    int m_phase[3];
    int m_duty[3];
    int m_cnt[3];
    int m_done[3];

    task automatic check(input string name, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_phase[i] = PhIdle;
        m_duty[i]  = 0;
        m_cnt[i]   = 0;
        m_done[i]  = 0;
    endtask

    task automatic model_step(input int i);
        m_done[i] = 0;
        if (!en) begin
            m_phase[i] = PhIdle;
            m_duty[i]  = 0;
            m_cnt[i]   = 0;
        end else if (m_phase[i] == PhIdle) begin
            m_phase[i] = PhUp;
            m_cnt[i]   = 0;
        end else if (co) begin
            m_cnt[i]++;
            if ((m_phase[i] == PhUp || m_phase[i] == PhDown) && m_cnt[i] == pd[i]) begin
                m_cnt[i] = 0;
                if (m_phase[i] == PhUp) begin
                    m_duty[i] = m_duty[i] + ps[i];
                    if (m_duty[i] >= pm[i] - 1) begin
                        m_duty[i]  = pm[i] - 1;
                        m_phase[i] = PhHi;
                    end
                end else begin
                    m_duty[i] = m_duty[i] - ps[i];
                    if (m_duty[i] <= 0) begin
                        m_duty[i]  = 0;
                        m_phase[i] = PhLo;
                    end
                end
            end else if ((m_phase[i] == PhHi || m_phase[i] == PhLo) && m_cnt[i] == ph[i]) begin
                m_cnt[i] = 0;
                if (m_phase[i] == PhHi) begin
                    m_phase[i] = PhDown;
                end else begin
                    m_phase[i] = PhUp;
                    m_done[i]  = 1;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) model_reset(i);
            else     model_step(i);
        end
    end

    function automatic int act_duty(input int i);
        case (i)
            0:       return int'(duty0);
            1:       return int'(duty1);
            default: return int'(duty2);
        endcase
    endfunction

    function automatic int act_rising(input int i);
        case (i)
            0:       return int'(rising0);
            1:       return int'(rising1);
            default: return int'(rising2);
        endcase
    endfunction

    function automatic int act_done(input int i);
        case (i)
            0:       return int'(done0);
            1:       return int'(done1);
            default: return int'(done2);
        endcase
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 3; i++) begin
                check("duty", i, act_duty(i), m_duty[i]);
                check("rising", i, act_rising(i),
                      (m_phase[i] == PhUp || m_phase[i] == PhHi) ? 1 : 0);
                check("cycle_done", i, act_done(i), m_done[i]);
            end
        end
    end

    // Returns on the falling edge just after the rising edge that sampled co=1.
    task automatic co_pulse(input int gap);
        repeat (gap - 1) @(negedge clk);
        co = 1'b1;
        @(negedge clk);
        co = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_duty", 0, int'(duty0), 0);
        check("rst_rising", 0, int'(rising0), 0);
        check("rst_done", 0, int'(done0), 0);
        cmp_on = 1;

        // Scripted breathing run, co every 16 clocks.
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            co_pulse(16);
            case (k)
                2: begin
                    check("co2_duty", 0, int'(duty0), 4);
                    check("co2_model", 0, m_duty[0], 4);
                    check("s15_up_duty", 1, int'(duty1), 15);
                end
                4: check("co4_duty", 0, int'(duty0), 8);
                5: begin
                    check("s15_down_duty", 1, int'(duty1), 0);
                    check("s15_hold_lo_rising", 1, int'(rising1), 0);
                end
                6: begin
                    check("co6_duty", 0, int'(duty0), 12);
                    check("s15_done", 1, int'(done1), 1);
                end
                8: begin
                    check("co8_duty", 0, int'(duty0), 15);
                    check("co8_hold_hi_rising", 0, int'(rising0), 1);
                    check("co8_model", 0, m_duty[0], 15);
                end
                9: begin
                    check("co9_down_rising", 0, int'(rising0), 0);
                    check("co9_duty", 0, int'(duty0), 15);
                end
                11: check("co11_duty", 0, int'(duty0), 11);
                13: check("co13_duty", 0, int'(duty0), 7);
                15: check("co15_duty", 0, int'(duty0), 3);
                17: begin
                    check("co17_duty", 0, int'(duty0), 0);
                    check("co17_rising", 0, int'(rising0), 0);
                end
                18: begin
                    check("co18_done", 0, int'(done0), 1);
                    check("co18_rising", 0, int'(rising0), 1);
                    check("co18_model_done", 0, m_done[0], 1);
                end
                default: ;
            endcase
            if (k != 18 && k != 17) check("no_early_done", 0, int'(done0), 0);
        end
        @(negedge clk);
        check("done_one_cycle", 0, int'(done0), 0);

        // Long co silence mid-step: nothing may advance.
        co_pulse(4);
        repeat (100) begin
            @(negedge clk);
            check("quiet_duty", 0, int'(duty0), 0);
        end
        co_pulse(1);
        check("quiet_then_step", 0, int'(duty0), 4);

        // Up to DOWN at duty 7 with one co already counted toward the next step.
        for (int k = 0; k < 12; k++) co_pulse(3);
        check("pre_drop_duty", 0, int'(duty0), 7);
        check("pre_drop_rising", 0, int'(rising0), 0);
        repeat (2) @(negedge clk);
        en = 1'b0;
        co = 1'b1;
        @(negedge clk);
        co = 1'b0;
        check("drop_duty", 0, int'(duty0), 0);
        check("drop_rising", 0, int'(rising0), 0);
        check("drop_done", 0, int'(done0), 0);
        co_pulse(2);
        check("idle_ignores_co", 0, int'(duty0), 0);

        // Async reset in HOLD_HI must clear outputs before the next clock edge.
        en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) co_pulse(2);
        check("pre_rst_duty", 0, int'(duty0), 15);
        check("pre_rst_rising", 0, int'(rising0), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_duty", 0, int'(duty0), 0);
        check("async_rst_rising", 0, int'(rising0), 0);
        check("async_rst_duty_s15", 1, int'(duty1), 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized co spacing with occasional enable drops and async resets.
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            co = !co && ($urandom_range(0, 2) == 0);
            if (en && $urandom_range(0, 1499) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
            if ($urandom_range(0, 2499) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                co  = 1'b0;
            end
        end
        @(negedge clk);
        cmp_on = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/duty_ramp.md
DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 The block SHALL have parameter M, default 256, meaning the PWM period length in counts of the downstream PWM generator; legal duty range is [0, M-1].
REQ-002 The block SHALL have parameter STEP, default 1, meaning the duty increment/decrement per step; legal range 1..M-1.
REQ-003 The block SHALL have parameter DIV, default 4, meaning the number of PWM periods (co pulses) per duty step; legal range >= 1.
REQ-004 The block SHALL have parameter HOLD, default 16, meaning the number of PWM periods to dwell at full and at zero duty; legal range >= 1.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, the asynchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit, the ramp enable, level-sensitive.
REQ-008 The block SHALL have port co, input, 1 bit, the period-boundary pulse from the downstream PWM generator, high for exactly one clk cycle per period.
REQ-009 The block SHALL have port duty, output, $clog2(M) bits, the registered duty value driven to the PWM generator's data input.
REQ-010 The block SHALL have port rising, output, 1 bit, high in states UP and HOLD_HI.
REQ-011 The block SHALL have port cycle_done, output, 1 bit, a one-cycle pulse at the end of each full breathing cycle.

Function
REQ-012 The block SHALL implement a five-state FSM: IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
REQ-013 The block SHALL change duty only on a clk edge where co=1, so the PWM generator sees a new value only at a period boundary.
REQ-014 In IDLE the block SHALL hold duty=0, clear both counters, and move to UP on the first edge with en=1; co is ignored in IDLE.
REQ-015 In UP/DOWN the block SHALL, on each co, increment div_cnt, or take a step and clear div_cnt when div_cnt==DIV-1.
REQ-016 An UP step SHALL clamp when duty >= M-1-STEP: duty<=M-1 and next state HOLD_HI; otherwise duty<=duty+STEP with no state change.
REQ-017 A DOWN step SHALL clamp when duty <= STEP: duty<=0 and next state HOLD_LO; otherwise duty<=duty-STEP.
REQ-018 Step arithmetic SHALL be evaluated at least $clog2(M)+1 bits wide, so no wrap-around occurs for any legal STEP.
REQ-019 In HOLD_HI/HOLD_LO the block SHALL, on each co, increment hold_cnt; when hold_cnt==HOLD-1 it SHALL clear hold_cnt and exit (HOLD_HI->DOWN, HOLD_LO->UP) with duty unchanged.
REQ-020 cycle_done SHALL be registered and high for exactly the one cycle following the HOLD_LO->UP transition edge.
REQ-021 en=0 in any state SHALL force IDLE, duty=0, and cleared counters on the next edge; this takes priority over a simultaneous co, and no cycle_done is produced.
REQ-022 rising SHALL be a registered or state-decoded output consistent with the current state and never high in IDLE.

Reset
REQ-023 While rst=1 the block SHALL immediately (asynchronously) hold state=IDLE, duty=0, rising=0, cycle_done=0, div_cnt=0, hold_cnt=0.
REQ-024 After rst deasserts the block SHALL resume from IDLE per REQ-014; a reset mid-ramp SHALL discard all progress.

Verification
REQ-025 The bench SHALL configure M=16, STEP=4, DIV=2, HOLD=1, en=1, with co pulsed every 16 clk -> duty SHALL be 4, 8, 12, 15 after co pulses 2, 4, 6, 8, with state HOLD_HI after pulse 8.
REQ-026 The bench SHALL continue the REQ-025 run -> DOWN after co 9; duty SHALL be 11, 7, 3, 0 after co 11, 13, 15, 17; HOLD_LO after co 17; cycle_done SHALL pulse once after co 18; rising SHALL be 1 again.
REQ-027 The bench SHALL hold co=0 for 100 cycles in UP -> duty SHALL remain constant and counters SHALL not advance.
REQ-028 The bench SHALL drop en in the same cycle as a stepping co while in DOWN with duty=7 -> next edge SHALL give duty=0, IDLE, cycle_done=0.
REQ-029 The bench SHALL assert rst asynchronously mid-cycle in HOLD_HI -> duty=0, rising=0 SHALL appear before the next clk edge.
REQ-030 The bench SHALL configure STEP=M-1=15 -> duty SHALL go 0->15 in one step and 15->0 in one step, with no wrap to nonzero values.
